// File: rtl/sram_mem_controller.sv
// Multi-cycle bridge from a 32-bit MEM-stage load/store to a 16-bit off-chip SRAM.
// Each access is two half-word phases of WAIT_CYCLES cycles; ready stalls the pipeline meanwhile.
module sram_mem_controller #(
  parameter int unsigned WAIT_CYCLES = 5,
  parameter int unsigned ADDR_BASE   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  logic [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        is_write;
  logic [16:0] word;
  logic [31:0] wdata;
  logic [15:0] read_lo;
  logic        dq_oe;
  logic [15:0] dq_out;
  logic [31:0] addr_off;
  logic        unused_addr_bits;

  assign addr_off         = address - 32'(ADDR_BASE);
  assign unused_addr_bits = ^{addr_off[31:19], addr_off[1:0]};

  assign SRAM_DQ   = dq_oe ? dq_out : 'z;
  assign ready     = ~(rd_en | wr_en) | (state == DONE);
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

  // Bus outputs are registered, so each one is loaded with the value it must
  // hold in the state being entered rather than the state being left.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      read_data <= '0;
      read_lo   <= '0;
      is_write  <= 1'b0;
      word      <= '0;
      wdata     <= '0;
      SRAM_ADDR <= '0;
      SRAM_WE_N <= 1'b1;
      dq_oe     <= 1'b0;
      dq_out    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_en | wr_en) begin
            is_write  <= wr_en;
            word      <= addr_off[18:2];
            wdata     <= write_data;
            cnt       <= '0;
            state     <= LOW;
            SRAM_ADDR <= {addr_off[18:2], 1'b0};
            SRAM_WE_N <= ~wr_en;
            dq_oe     <= wr_en;
            dq_out    <= write_data[15:0];
          end
        end
        LOW: begin
          if (cnt == LAST) begin
            if (!is_write) read_lo <= SRAM_DQ;
            cnt       <= '0;
            state     <= HIGH;
            SRAM_ADDR <= {word, 1'b1};
            SRAM_WE_N <= ~is_write;
            dq_out    <= wdata[31:16];
          end else begin
            cnt       <= cnt + 4'd1;
            SRAM_WE_N <= ~(is_write && ((cnt + 4'd1) < LAST));
          end
        end
        HIGH: begin
          if (cnt == LAST) begin
            if (!is_write) read_data <= {SRAM_DQ, read_lo};
            cnt       <= '0;
            state     <= DONE;
            SRAM_WE_N <= 1'b1;
            dq_oe     <= 1'b0;
          end else begin
            cnt       <= cnt + 4'd1;
            SRAM_WE_N <= ~(is_write && ((cnt + 4'd1) < LAST));
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
